dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port data memory (12-bit word address, 32-bit data) between the processor's data port (port 0) and a loader/debug port (port 1). It sits between the requesters and the dmem syncram, all in one clock domain. It grants at most one access per cycle with round-robin fairness, drives the memory address, data and write enable, and returns read data to the issuing port after the fixed memory read latency.

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/rd_return_pipe.sv | 41 ++++
 rtl/dmem_arbiter.sv | 116 +++++++++++
 tb/tb_dmem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the dmem arbiter: port identifiers, default widths
// and the read-return pipeline entry.
package dmem_arb_pkg;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;

    typedef struct packed {
        logic valid;
        logic id;
    } ret_entry_t;

endpackage

// File: rtl/rd_return_pipe.sv
// Fixed-depth shift register that tracks which port owns each in-flight read,
// so returning memory data can be steered once the syncram latency has elapsed.
module rd_return_pipe
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       srst,
    input  ret_entry_t i_push,
    output ret_entry_t o_tail
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            ret_entry_t r_entry;

            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (srst) begin
                        r_entry <= '0;
                    end else begin
                        r_entry <= i_push;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk) begin
                    if (srst) begin
                        r_entry <= '0;
                    end else begin
                        r_entry <= g_stage[gi-1].r_entry;
                    end
                end
            end
        end
    endgenerate

    assign o_tail = g_stage[DEPTH-1].r_entry;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port dmem between the CPU data port
// and the loader/debug port, with read data steered back after RD_LAT cycles.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    logic              r_last_grant;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_any;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_ret0;
    logic              w_ret1;
    ret_entry_t        w_push;
    ret_entry_t        w_tail;

    // On a contest the port that did not win last time goes first.
    assign w_gnt0 = !reset && req0 && (!req1 || (r_last_grant == PORT_LDR));
    assign w_gnt1 = !reset && req1 && (!req0 || (r_last_grant == PORT_CPU));
    assign w_any  = w_gnt0 | w_gnt1;

    assign w_sel_we   = w_gnt1 ? we1    : we0;
    assign w_sel_addr = w_gnt1 ? addr1  : addr0;
    assign w_sel_data = w_gnt1 ? wdata1 : wdata0;

    assign ack0        = w_gnt0;
    assign ack1        = w_gnt1;
    assign mem_wren    = w_any & w_sel_we;
    assign mem_address = w_any ? w_sel_addr : r_mem_address;
    assign mem_data    = w_any ? w_sel_data : r_mem_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant  <= PORT_LDR;
            r_mem_address <= '0;
            r_mem_data    <= '0;
        end else if (w_any) begin
            r_last_grant  <= w_gnt1;
            r_mem_address <= w_sel_addr;
            r_mem_data    <= w_sel_data;
        end
    end

    assign w_push = '{valid: w_any & ~w_sel_we, id: w_gnt1};

    rd_return_pipe #(
        .DEPTH (RD_LAT)
    ) u_ret_pipe (
        .clk    (clock),
        .srst   (reset),
        .i_push (w_push),
        .o_tail (w_tail)
    );

    assign w_ret0 = w_tail.valid && (w_tail.id == PORT_CPU);
    assign w_ret1 = w_tail.valid && (w_tail.id == PORT_LDR);

    // rdata of the port not being served keeps its last returned word.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_ret0;
            r_rvalid1 <= w_ret1;
            if (w_ret0) begin
                r_rdata0 <= mem_q;
            end
            if (w_ret1) begin
                r_rdata1 <= mem_q;
            end
        end
    end

    assign rvalid0 = r_rvalid0 & ~reset;
    assign rvalid1 = r_rvalid1 & ~reset;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Two arbiter instances (RD_LAT=1 and RD_LAT=2) share one stimulus stream and are
// compared cycle by cycle against a transaction-level model of grants, memory and returns.
module tb_dmem_arbiter;

    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int MAXC = 8192;
    localparam int NW   = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req_t   [2];
    logic          we_t    [2];
    logic [AW-1:0] addr_t  [2];
    logic [DW-1:0] wdata_t [2];

    logic          ack0_w  [2];
    logic          ack1_w  [2];
    logic          rv0_w   [2];
    logic          rv1_w   [2];
    logic          wren_w  [2];
    logic [DW-1:0] rd0_w   [2];
    logic [DW-1:0] rd1_w   [2];
    logic [DW-1:0] mdata_w [2];
    logic [DW-1:0] q_w     [2];
    logic [AW-1:0] maddr_w [2];

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 'h010) return 32'hDEAD_BEEF;
        return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_inst
            localparam int LAT = gi + 1;
            logic [DW-1:0] ram   [NW];
            logic [DW-1:0] qpipe [LAT];

            initial begin
                for (int i = 0; i < NW; i++) ram[i] = init_val(i);
            end

            // Syncram stand-in: registered address, LAT cycles to q.
            always @(posedge clk) begin
                if (wren_w[gi]) ram[maddr_w[gi]] <= mdata_w[gi];
                qpipe[0] <= ram[maddr_w[gi]];
                for (int i = 1; i < LAT; i++) qpipe[i] <= qpipe[i-1];
            end
            assign q_w[gi] = qpipe[LAT-1];

            dmem_arbiter #(
                .ADDR_W (AW),
                .DATA_W (DW),
                .RD_LAT (LAT)
            ) u_dut (
                .clock       (clk),
                .reset       (rst),
                .req0        (req_t[0]),
                .req1        (req_t[1]),
                .we0         (we_t[0]),
                .we1         (we_t[1]),
                .addr0       (addr_t[0]),
                .addr1       (addr_t[1]),
                .wdata0      (wdata_t[0]),
                .wdata1      (wdata_t[1]),
                .ack0        (ack0_w[gi]),
                .ack1        (ack1_w[gi]),
                .rvalid0     (rv0_w[gi]),
                .rvalid1     (rv1_w[gi]),
                .rdata0      (rd0_w[gi]),
                .rdata1      (rd1_w[gi]),
                .mem_address (maddr_w[gi]),
                .mem_data    (mdata_w[gi]),
                .mem_wren    (wren_w[gi]),
                .mem_q       (q_w[gi])
            );
        end
    endgenerate

    // Reference model state
    logic [DW-1:0] m_mem   [NW];
    logic          m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_rdata [2][2];
    bit            sched_v [2][MAXC];
    bit            sched_p [2][MAXC];
    logic [DW-1:0] sched_d [2][MAXC];
    bit            pend    [2];
    int            cyc;
    int            n_checks;
    int            n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic string tg(input int k, input string name);
        return $sformatf("L%0d.%s", k + 1, name);
    endfunction

    task automatic put(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (!pend[p]) begin
            req_t[p]   = 1'b1;
            we_t[p]    = we;
            addr_t[p]  = a;
            wdata_t[p] = d;
            pend[p]    = 1'b1;
        end
    endtask

    // mode 0: random traffic, 1: both ports always asking, 2: only directed requests
    task automatic drive(input int mode);
        for (int p = 0; p < 2; p++) begin
            if (!pend[p]) begin
                if (mode == 1 || (mode == 0 && $urandom_range(99) < 55))
                    put(p, 1'($urandom_range(1)), 12'($urandom_range(15)), $urandom);
                else
                    req_t[p] = 1'b0;
            end
        end
    endtask

    // Called just after a falling edge with inputs driven; ends at the next falling edge.
    task automatic step();
        int            gp;
        logic          g   [2];
        logic          rv  [2];
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        #1;
        gp = -1;
        if (!rst) begin
            if (req_t[0] && req_t[1]) gp = m_last ? 0 : 1;
            else if (req_t[0])        gp = 0;
            else if (req_t[1])        gp = 1;
        end
        g[0] = (gp == 0);
        g[1] = (gp == 1);
        exp_we   = 1'b0;
        exp_addr = m_addr;
        exp_data = m_data;
        if (gp >= 0) begin
            exp_we   = we_t[gp];
            exp_addr = addr_t[gp];
            exp_data = wdata_t[gp];
        end

        for (int k = 0; k < 2; k++) begin
            rv[0] = 1'b0;
            rv[1] = 1'b0;
            if (sched_v[k][cyc]) begin
                m_rdata[k][sched_p[k][cyc]] = sched_d[k][cyc];
                rv[sched_p[k][cyc]] = !rst;
            end
            check(tg(k, "ack0"),        32'(ack0_w[k]),  32'(g[0]));
            check(tg(k, "ack1"),        32'(ack1_w[k]),  32'(g[1]));
            check(tg(k, "mem_wren"),    32'(wren_w[k]),  32'(exp_we));
            check(tg(k, "mem_address"), 32'(maddr_w[k]), 32'(exp_addr));
            check(tg(k, "mem_data"),    mdata_w[k],      exp_data);
            check(tg(k, "rvalid0"),     32'(rv0_w[k]),   32'(rv[0]));
            check(tg(k, "rvalid1"),     32'(rv1_w[k]),   32'(rv[1]));
            check(tg(k, "rdata0"),      rd0_w[k],        m_rdata[k][0]);
            check(tg(k, "rdata1"),      rd1_w[k],        m_rdata[k][1]);
        end

        if (rst) begin
            m_last = 1'b1;
            m_addr = '0;
            m_data = '0;
            for (int k = 0; k < 2; k++) begin
                m_rdata[k][0] = '0;
                m_rdata[k][1] = '0;
                for (int j = cyc + 1; j < cyc + 8; j++) sched_v[k][j] = 1'b0;
            end
        end else if (gp >= 0) begin
            $display("cyc %0d port %0d %s addr %03h data %08h", cyc, gp,
                     we_t[gp] ? "WR" : "RD", addr_t[gp],
                     we_t[gp] ? wdata_t[gp] : m_mem[addr_t[gp]]);
            m_last = 1'(gp);
            m_addr = addr_t[gp];
            m_data = wdata_t[gp];
            if (we_t[gp]) begin
                m_mem[addr_t[gp]] = wdata_t[gp];
            end else begin
                for (int k = 0; k < 2; k++) begin
                    sched_v[k][cyc + 2 + k] = 1'b1;
                    sched_p[k][cyc + 2 + k] = 1'(gp);
                    sched_d[k][cyc + 2 + k] = m_mem[addr_t[gp]];
                end
            end
        end

        @(posedge clk);
        cyc++;
        if (gp >= 0) pend[gp] = 1'b0;
        @(negedge clk);
    endtask

    task automatic run(input int mode);
        drive(mode);
        step();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        for (int i = 0; i < NW; i++) m_mem[i] = init_val(i);
        m_last = 1'b1;
        m_addr = '0;
        m_data = '0;
        for (int k = 0; k < 2; k++) begin
            m_rdata[k][0] = '0;
            m_rdata[k][1] = '0;
        end
        for (int p = 0; p < 2; p++) begin
            pend[p]    = 1'b0;
            req_t[p]   = 1'b0;
            we_t[p]    = 1'b0;
            addr_t[p]  = '0;
            wdata_t[p] = '0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        run(2);
        rst = 1'b0;

        // Single port 0 read of the preloaded word
        put(0, 1'b0, 12'h010, 32'h0);
        repeat (5) run(2);

        // Both ports writing, held across four contests
        for (int i = 0; i < 4; i++) begin
            put(0, 1'b1, 12'h001, 32'h11);
            put(1, 1'b1, 12'h002, 32'h22);
            run(2);
        end
        repeat (2) run(2);
        put(1, 1'b0, 12'h001, 32'h0);
        put(0, 1'b0, 12'h002, 32'h0);
        repeat (5) run(2);

        // Port 1 write then port 0 read of the same word
        put(1, 1'b1, 12'h100, 32'hCAFE_F00D);
        run(2);
        put(0, 1'b0, 12'h100, 32'h0);
        repeat (5) run(2);

        // Back-to-back port 0 reads
        for (int i = 0; i < 4; i++) begin
            put(0, 1'b0, 12'(i), 32'h0);
            run(2);
        end
        repeat (4) run(2);

        // Idle
        repeat (10) run(2);

        // Reset with a read in flight, then a contest right after
        put(0, 1'b0, 12'h003, 32'h0);
        run(2);
        rst = 1'b1;
        repeat (2) run(2);
        rst = 1'b0;
        put(0, 1'b1, 12'h020, 32'h1234_5678);
        put(1, 1'b1, 12'h021, 32'h8765_4321);
        repeat (6) run(2);

        // Random traffic with contention bursts and occasional resets
        for (int b = 0; b < 6; b++) begin
            repeat (250) run(($urandom_range(9) == 0) ? 1 : 0);
            rst = 1'b1;
            run(0);
            rst = 1'b0;
        end
        repeat (8) run(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
